bidir_piso_serializer: RTL and testbench

- Parallel-in, serial-out transmitter. It is the transmit end of our 4-bit bidirectional serial-in shift-register receiver.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled cycle.
- Bit order is MSB-first for left-shift frames and LSB-first for right-shift frames, so a receiver with the same dir setting reassembles the word exactly.
- Sits between the parallel datapath and the serial link.

---
 rtl/bidir_shift_pkg.sv | 22 ++
 rtl/bidir_piso_core.sv | 60 ++++++
 rtl/bidir_piso_serializer.sv | 70 +++++++
 tb/tb_bidir_piso_serializer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bidir_shift_pkg.sv
// Definitions shared by the bidirectional serializer and its matching receiver.
// BIDIR_PISO_PARITY_EN appends an even-parity bit to every frame.
package bidir_shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Number of serial bits in one frame, including the optional parity bit.
  function automatic int frame_bits(input int width);
`ifdef BIDIR_PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/bidir_piso_core.sv
// Serializer datapath: shift register, direction latch and serial output mux.
// BIDIR_PISO_PARITY_EN adds a parity register and a parity output slot.
module bidir_piso_core
  import bidir_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             active,
`ifdef BIDIR_PISO_PARITY_EN
  input  logic             parity_slot,
`endif
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  output logic             serial_out
);

  logic [WIDTH-1:0] sreg;
  logic             dir_q;
`ifdef BIDIR_PISO_PARITY_EN
  logic             parity_q;
`endif

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg  <= '0;
      dir_q <= DIR_RIGHT;
`ifdef BIDIR_PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (load) begin
      // A load wins over a shift so the next frame follows with no gap bit.
      sreg  <= data;
      dir_q <= dir;
`ifdef BIDIR_PISO_PARITY_EN
      parity_q <= ^data;
`endif
    end else if (shift) begin
      if (dir_q == DIR_LEFT) sreg <= {sreg[WIDTH-2:0], 1'b0};
      else                   sreg <= {1'b0, sreg[WIDTH-1:1]};
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    serial_out = 1'b0;
    if (active) begin
      serial_out = (dir_q == DIR_LEFT) ? sreg[WIDTH-1] : sreg[0];
`ifdef BIDIR_PISO_PARITY_EN
      if (parity_slot) serial_out = parity_q;
`endif
    end
  end

endmodule

// File: rtl/bidir_piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and shift-enable pacing.
// BIDIR_PISO_PARITY_EN extends each frame with an even-parity bit.
module bidir_piso_serializer
  import bidir_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_dir,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_last,
  output logic             done
);

  localparam int CNT_W    = $clog2(WIDTH + 1);
  localparam int LAST_CNT = frame_bits(WIDTH) - 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             consume;

  assign serial_valid = (state == SHIFT);
  assign frame_last   = (state == SHIFT) && (cnt == CNT_W'(LAST_CNT));
  assign consume      = (state == SHIFT) && shift_en;
  assign load_ready   = (state == IDLE) || (consume && frame_last);
  assign accept       = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= consume && frame_last;
      if (accept) begin
        state <= SHIFT;
        cnt   <= '0;
      end else if (consume) begin
        if (frame_last) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  bidir_piso_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .shift       (consume),
    .active      (serial_valid),
`ifdef BIDIR_PISO_PARITY_EN
    .parity_slot (cnt == CNT_W'(WIDTH)),
`endif
    .data        (load_data),
    .dir         (load_dir),
    .serial_out  (serial_out)
  );

endmodule

// File: tb/tb_bidir_piso_serializer.sv
// Scoreboard bench for bidir_piso_serializer; honours BIDIR_PISO_PARITY_EN.
module tb_bidir_piso_serializer;

  localparam int W = 4;

  typedef struct {
    bit b;
    bit last;
  } sbit_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_dir = 1'b0;
  logic         load_ready;
  logic         shift_en = 1'b0;
  logic         serial_out;
  logic         serial_valid;
  logic         frame_last;
  logic         done;

  sbit_t q[$];
  bit    en_pat[$];
  bit    en_rand = 1'b0;
  bit    mon_en = 1'b0;
  bit    done_exp = 1'b0;
  int    checks = 0;
  int    errors = 0;

  bidir_piso_serializer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_dir     (load_dir),
    .load_ready   (load_ready),
    .shift_en     (shift_en),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_last   (frame_last),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected frame: data bits in wire order, then parity when enabled.
  task automatic push_frame(input logic [W-1:0] d, input logic dir);
    int n;
    n = W;
`ifdef BIDIR_PISO_PARITY_EN
    n = W + 1;
`endif
    for (int i = 0; i < W; i++) begin
      sbit_t s;
      s.b    = dir ? d[W-1-i] : d[i];
      s.last = (i == n - 1);
      q.push_back(s);
    end
`ifdef BIDIR_PISO_PARITY_EN
    begin
      sbit_t p;
      p.b    = ^d;
      p.last = 1'b1;
      q.push_back(p);
    end
`endif
  endtask

  // Monitor: compares what the DUT presents this cycle, then advances the model.
  always @(negedge clk) begin
    if (mon_en) begin
      bit ready_exp;
      check("serial_valid", 32'(serial_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        check("serial_out", 32'(serial_out), 32'(q[0].b));
        check("frame_last", 32'(frame_last), 32'(q[0].last));
      end else begin
        check("serial_out_idle", 32'(serial_out), 32'd0);
        check("frame_last_idle", 32'(frame_last), 32'd0);
      end
      check("done", 32'(done), 32'(done_exp));
      ready_exp = (q.size() == 0) || (shift_en && q[0].last);
      check("load_ready", 32'(load_ready), 32'(ready_exp));
      done_exp = (q.size() > 0) && shift_en && q[0].last;
      if (q.size() > 0 && shift_en) void'(q.pop_front());
      if (rst) begin
        q.delete();
        done_exp = 1'b0;
      end
    end
  end

  // shift_en source: queued pattern first, else random or constant high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (en_pat.size() > 0) shift_en = en_pat.pop_front();
      else if (en_rand)      shift_en = 1'($urandom_range(0, 1));
      else                   shift_en = 1'b1;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic dir);
    int  waited;
    bit  acc;
    waited = 0;
    acc    = 1'b0;
    @(posedge clk);
    #1;
    load_valid = 1'b1;
    load_data  = d;
    load_dir   = dir;
    while (!acc) begin
      @(negedge clk);
      #1;
      if (load_ready) begin
        acc = 1'b1;
        push_frame(d, dir);
      end else if (++waited > 200) begin
        errors++;
        $display("FAIL accept_timeout: got no load_ready expected acceptance within 200 cycles");
        break;
      end
    end
  endtask

  task automatic drop();
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = W'($urandom);
    load_dir   = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    en_rand = 1'b0;
    while (q.size() > 0) begin
      @(negedge clk);
      if (++waited > 100) begin
        errors++;
        $display("FAIL drain_timeout: got %0d bits pending expected 0", q.size());
        q.delete();
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames in both directions, shift_en held high.
    send(4'b1011, 1'b1); drop(); drain();
    send(4'b1011, 1'b0); drop(); drain();

    // Stalled frame: each bit must hold while shift_en is low.
    send(4'b0110, 1'b1);
    en_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    drop(); drain();

    // Back-to-back frames with opposite directions.
    send(4'hA, 1'b1); send(4'h5, 1'b0); drop(); drain();

    // Abort mid-frame after two bits.
    send(4'hC, 1'b1); drop();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    send(4'hF, 1'b1); drop(); drain();

    // Randomised traffic: random data, direction, pacing and gaps.
    en_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        drop();
        repeat ($urandom_range(0, 6)) @(posedge clk);
      end
    end
    drop();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "bench timeout");
  end

endmodule
